fb_write_scheduler: RTL and testbench
=====================================

// Module: fb_write_scheduler
// PURPOSE
//  Sequences every write into the 1-bit-per-pixel VGA frame-buffer RAM (wraddress/data/wren).
//  Arbitrates between two requesters:
//   - word requester: coprocessor result word, 32 pixels from a base address;
//   - clear requester: fills the whole buffer with one pixel value.
//  Serialises each granted job into single-pixel RAM writes, one per clock.
//  Returns a one-cycle done pulse to the requester that owned the job.
// PARAMETERS
//  ADDR_W  12  frame-buffer address width; DEPTH = 2**ADDR_W pixels
//  WORD_W  32  pixels per word job
// PORTS
//  clock       in   1       single system clock, rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  word_start  in   1       1-cycle pulse: request a word job
//  word_data   in   WORD_W  pixel bits, bit 0 written first
//  word_base   in   ADDR_W  address of pixel 0
//  clr_start   in   1       1-cycle pulse: request a clear job
//  clr_value   in   1       value written to every pixel
//  data        out  1       RAM write data
//  wraddress   out  ADDR_W  RAM write address
//  wren        out  1       RAM write enable
//  word_done   out  1       1-cycle pulse: word job finished
//  clr_done    out  1       1-cycle pulse: clear job finished
//  busy        out  1       job in progress or request pending
// BEHAVIOUR
//  - Outputs are registered.
//  - Reset (async, reset_n=0):
//    - data=0, wraddress=0, wren=0, word_done=0, clr_done=0, busy=0;
//    - both pending flags cleared; state=IDLE; last_grant=CLR;
//    - an in-flight job is abandoned with no done pulse.
//  - Pending buffers, one-deep per requester:
//    - a start pulse sets that requester's pending flag and captures its operands;
//    - a start while the same requester is already pending overwrites the operands
//      (latest wins; a single done is returned);
//    - a start while that requester's job is running sets pending for a new job.
//  - State machine: IDLE, WORD, CLEAR, DONE.
//  - IDLE:
//    - if both are pending, grant the requester not named by last_grant (round-robin);
//    - otherwise grant whichever is pending;
//    - on grant: clear its pending flag, update last_grant, reset the counter to 0, and
//      go to WORD or CLEAR;
//    - a start arriving the same cycle as IDLE sampling is seen next cycle (1-cycle latency).
//  - WORD, counter k = 0..WORD_W-1:
//    - drive wren=1, data=word_data[k], wraddress=(base+k) mod DEPTH; wraps at DEPTH-1 -> 0;
//    - after k=WORD_W-1 go to DONE.
//  - CLEAR, counter k = 0..DEPTH-1:
//    - drive wren=1, data=clr_value, wraddress=k;
//    - after k=DEPTH-1 go to DONE.
//  - DONE, 1 cycle:
//    - wren=0, data=0;
//    - pulse the owner's done; the other done stays 0;
//    - go to IDLE; arbitration resumes the following cycle.
//  - Timing: wren rises the cycle after the grant.
//    - a word job occupies exactly WORD_W consecutive wren cycles;
//    - a clear job occupies DEPTH consecutive wren cycles;
//    - no gaps and no preemption.
//  - wraddress holds its last value while wren=0.
//  - busy = (state != IDLE) | word_pend | clr_pend.
// TESTING
//  1. word_start, base=0x010, data=0xA5A50001 -> 32 wren cycles:
//     addr 0x010..0x02F, data 1,0,0,... (LSB first); word_done 1 cycle after addr 0x02F.
//  2. Wrap: base=0xFFA, data=0xFFFFFFFF -> addr 0xFFA..0xFFF then 0x000..0x019;
//     data=1 throughout; exactly 32 writes.
//  3. Simultaneous word_start and clr_start after reset (last_grant=CLR):
//     -> word job runs first; then clear writes 0x000..0xFFF;
//     word_done precedes clr_done by 4096+2 cycles.
//  4. clr_start, clr_value=1, then word_start during the clear -> clear finishes
//     uninterrupted; word job starts 2 cycles after clr_done; busy stays 1 throughout.
//  5. Reset at clear address 0x100 -> wren=0 immediately (asynchronous); no clr_done;
//     after release, idle with busy=0 and no spurious writes.
//  6. Two word_starts while pending (data 0x1, then 0x2) -> one job with data 0x2;
//     single word_done.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Frame-buffer write scheduler: arbitrates a 32-pixel word requester against a
// full-buffer clear requester and serialises each job into one pixel write per clock.
module fb_write_scheduler #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              word_start,
    input  logic [WORD_W-1:0] word_data,
    input  logic [ADDR_W-1:0] word_base,
    input  logic              clr_start,
    input  logic              clr_value,
    output logic              data,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wren,
    output logic              word_done,
    output logic              clr_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WORD  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        G_WORD = 1'b0,
        G_CLR  = 1'b1
    } grant_t;

    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST  = {ADDR_W{1'b1}};

    state_t              state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    logic                word_pend_q, word_pend_d;
    logic                clr_pend_q, clr_pend_d;
    logic [WORD_W-1:0]   wp_data_q, wp_data_d;
    logic [ADDR_W-1:0]   wp_base_q, wp_base_d;
    logic                cp_val_q, cp_val_d;
    logic [WORD_W-1:0]   job_data_q, job_data_d;
    logic [ADDR_W-1:0]   job_base_q, job_base_d;
    logic                job_val_q, job_val_d;
    logic                job_clr_q, job_clr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                data_q, data_d;
    logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
    logic                wren_q, wren_d;
    logic                word_done_q, word_done_d;
    logic                clr_done_q, clr_done_d;
    logic                busy_q, busy_d;
    logic                word_grant_s;
    logic                clr_grant_s;

    // Round-robin grant decision, only evaluated while idle.
    always_comb begin
        word_grant_s = 1'b0;
        clr_grant_s  = 1'b0;
        if (state_q == S_IDLE) begin
            if (word_pend_q && clr_pend_q) begin
                if (last_grant_q == G_CLR) begin
                    word_grant_s = 1'b1;
                end else begin
                    clr_grant_s = 1'b1;
                end
            end else begin
                word_grant_s = word_pend_q;
                clr_grant_s  = clr_pend_q;
            end
        end else begin
            word_grant_s = 1'b0;
            clr_grant_s  = 1'b0;
        end
    end

    // One-deep pending buffers; a new start beats a same-cycle grant so it is never lost.
    always_comb begin
        word_pend_d = word_start | (word_pend_q & ~word_grant_s);
        clr_pend_d  = clr_start  | (clr_pend_q  & ~clr_grant_s);
        wp_data_d   = word_start ? word_data : wp_data_q;
        wp_base_d   = word_start ? word_base : wp_base_q;
        cp_val_d    = clr_start  ? clr_value : cp_val_q;
    end

    // Job sequencer: next state, counter and registered RAM-side outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        job_data_d   = job_data_q;
        job_base_d   = job_base_q;
        job_val_d    = job_val_q;
        job_clr_d    = job_clr_q;
        cnt_d        = cnt_q;
        data_d       = 1'b0;
        wraddress_d  = wraddress_q;
        wren_d       = 1'b0;
        word_done_d  = 1'b0;
        clr_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (word_grant_s) begin
                    state_d      = S_WORD;
                    last_grant_d = G_WORD;
                    cnt_d        = {ADDR_W{1'b0}};
                    job_data_d   = wp_data_q;
                    job_base_d   = wp_base_q;
                    job_clr_d    = 1'b0;
                end else if (clr_grant_s) begin
                    state_d      = S_CLEAR;
                    last_grant_d = G_CLR;
                    cnt_d        = {ADDR_W{1'b0}};
                    job_val_d    = cp_val_q;
                    job_clr_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WORD: begin
                // Pixel bits leave LSB first through a shift register; address wraps naturally.
                wren_d      = 1'b1;
                data_d      = job_data_q[0];
                wraddress_d = job_base_q + cnt_q;
                job_data_d  = job_data_q >> 1;
                if (cnt_q == WORD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            S_CLEAR: begin
                wren_d      = 1'b1;
                data_d      = job_val_q;
                wraddress_d = cnt_q;
                if (cnt_q == CLR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                word_done_d = ~job_clr_q;
                clr_done_d  = job_clr_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Computed from next-cycle values so the registered flag matches the current state.
        busy_d = (state_d != S_IDLE) | word_pend_d | clr_pend_d;
    end

    // State, buffer and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= G_CLR;
            word_pend_q  <= 1'b0;
            clr_pend_q   <= 1'b0;
            wp_data_q    <= {WORD_W{1'b0}};
            wp_base_q    <= {ADDR_W{1'b0}};
            cp_val_q     <= 1'b0;
            job_data_q   <= {WORD_W{1'b0}};
            job_base_q   <= {ADDR_W{1'b0}};
            job_val_q    <= 1'b0;
            job_clr_q    <= 1'b0;
            cnt_q        <= {ADDR_W{1'b0}};
            data_q       <= 1'b0;
            wraddress_q  <= {ADDR_W{1'b0}};
            wren_q       <= 1'b0;
            word_done_q  <= 1'b0;
            clr_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            word_pend_q  <= word_pend_d;
            clr_pend_q   <= clr_pend_d;
            wp_data_q    <= wp_data_d;
            wp_base_q    <= wp_base_d;
            cp_val_q     <= cp_val_d;
            job_data_q   <= job_data_d;
            job_base_q   <= job_base_d;
            job_val_q    <= job_val_d;
            job_clr_q    <= job_clr_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            wraddress_q  <= wraddress_d;
            wren_q       <= wren_d;
            word_done_q  <= word_done_d;
            clr_done_q   <= clr_done_d;
            busy_q       <= busy_d;
        end
    end

    assign data      = data_q;
    assign wraddress = wraddress_q;
    assign wren      = wren_q;
    assign word_done = word_done_q;
    assign clr_done  = clr_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: a table of word jobs plus hand-written
// sequences for arbitration, clear/word interaction, mid-job reset and pending overwrite.
module tb_fb_write_scheduler;

    localparam int ADDR_W = 12;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 4096;

    logic              clock;
    logic              reset_n;
    logic              word_start;
    logic [WORD_W-1:0] word_data;
    logic [ADDR_W-1:0] word_base;
    logic              clr_start;
    logic              clr_value;
    logic              data;
    logic [ADDR_W-1:0] wraddress;
    logic              wren;
    logic              word_done;
    logic              clr_done;
    logic              busy;

    fb_write_scheduler #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .word_start (word_start),
        .word_data  (word_data),
        .word_base  (word_base),
        .clr_start  (clr_start),
        .clr_value  (clr_value),
        .data       (data),
        .wraddress  (wraddress),
        .wren       (wren),
        .word_done  (word_done),
        .clr_done   (clr_done),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] wdata;
        logic [11:0] base;
        logic [11:0] first;
        logic [11:0] last;
    } vec_t;

    vec_t vecs [5];

    int tests_run = 0;
    int tests_failed = 0;

    int cyc = 0;
    int wd_cnt, cd_cnt, wd_cyc, cd_cyc, busy_low;
    logic [11:0] wq_addr [$];
    logic        wq_data [$];
    int          wq_cyc  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        wd_cnt = 0; cd_cnt = 0; wd_cyc = 0; cd_cyc = 0; busy_low = 0;
    endtask

    // Advance to the next falling edge and log everything the DUT did.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (wren) begin
            wq_addr.push_back(wraddress);
            wq_data.push_back(data);
            wq_cyc.push_back(cyc);
        end
        if (word_done) begin wd_cnt++; wd_cyc = cyc; end
        if (clr_done)  begin cd_cnt++; cd_cyc = cyc; end
        if (!busy) busy_low++;
    endtask

    task automatic run_word(input vec_t v);
        int s, t, errs;
        clear_log();
        word_data = v.wdata; word_base = v.base; word_start = 1'b1;
        s = cyc;
        step();
        word_start = 1'b0;
        t = 0;
        while (wd_cnt == 0 && t < 200) begin step(); t++; end
        check("word_done_seen", 32'(wd_cnt), 32'd1);
        check("word_nwrites", 32'(wq_addr.size()), 32'd32);
        errs = 0;
        for (int k = 0; k < wq_addr.size(); k++) begin
            if (wq_addr[k] !== 12'(v.base + 12'(k))) errs++;
            if (wq_data[k] !== v.wdata[k]) errs++;
            if (wq_cyc[k] !== wq_cyc[0] + k) errs++;
        end
        check("word_stream_errs", 32'(errs), 32'd0);
        if (wq_addr.size() == 32) begin
            check("word_first_addr", 32'(wq_addr[0]), 32'(v.first));
            check("word_last_addr", 32'(wq_addr[31]), 32'(v.last));
            check("word_latency", 32'(wq_cyc[0] - s), 32'd3);
            check("word_done_after_last", 32'(wd_cyc - wq_cyc[31]), 32'd1);
        end else begin
            check("word_stream_length", 32'(wq_addr.size()), 32'd32);
        end
        step();
        check("word_done_pulse_width", 32'(word_done), 32'd0);
        check("word_idle_busy", 32'(busy), 32'd0);
        check("word_idle_wren", 32'(wren), 32'd0);
    endtask

    initial begin
        int t, errs;

        vecs[0] = '{wdata: 32'hA5A5_0001, base: 12'h010, first: 12'h010, last: 12'h02F};
        vecs[1] = '{wdata: 32'hFFFF_FFFF, base: 12'hFFA, first: 12'hFFA, last: 12'h019};
        vecs[2] = '{wdata: 32'h0000_0000, base: 12'hFE0, first: 12'hFE0, last: 12'hFFF};
        vecs[3] = '{wdata: 32'h8000_0000, base: 12'h7FF, first: 12'h7FF, last: 12'h81E};
        vecs[4] = '{wdata: 32'h1234_5678, base: 12'h000, first: 12'h000, last: 12'h01F};

        reset_n = 1'b0; word_start = 1'b0; clr_start = 1'b0;
        word_data = 32'h0; word_base = 12'h0; clr_value = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_wren", 32'(wren), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        check("reset_addr", 32'(wraddress), 32'd0);
        check("reset_dones", 32'({word_done, clr_done}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i]);
        end

        // Simultaneous requests after reset: word wins since last_grant starts at CLR.
        reset_n = 1'b0; step(); reset_n = 1'b1; step();
        clear_log();
        word_data = 32'hFFFF_0000; word_base = 12'h400; clr_value = 1'b0;
        word_start = 1'b1; clr_start = 1'b1;
        step();
        word_start = 1'b0; clr_start = 1'b0;
        t = 0;
        while (cd_cnt == 0 && t < 5000) begin step(); t++; end
        check("arb_word_done_cnt", 32'(wd_cnt), 32'd1);
        check("arb_clr_done_cnt", 32'(cd_cnt), 32'd1);
        check("arb_done_spacing", 32'(cd_cyc - wd_cyc), 32'd4098);
        check("arb_nwrites", 32'(wq_addr.size()), 32'(32 + DEPTH));
        errs = 0;
        for (int k = 0; k < wq_addr.size(); k++) begin
            if (k < 32) begin
                if (wq_addr[k] !== 12'(12'h400 + 12'(k))) errs++;
                if (wq_data[k] !== (k >= 16)) errs++;
            end else begin
                if (wq_addr[k] !== 12'(k - 32)) errs++;
                if (wq_data[k] !== 1'b0) errs++;
            end
        end
        check("arb_stream_errs", 32'(errs), 32'd0);

        // Word request during a clear waits; busy stays high until the word job ends.
        step();
        clear_log();
        clr_value = 1'b1; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (50) step();
        word_data = 32'h0000_00FF; word_base = 12'h123; word_start = 1'b1;
        step();
        word_start = 1'b0;
        t = 0;
        while (wd_cnt == 0 && t < 5000) begin step(); t++; end
        check("cw_clr_done_cnt", 32'(cd_cnt), 32'd1);
        check("cw_word_done_cnt", 32'(wd_cnt), 32'd1);
        check("cw_nwrites", 32'(wq_addr.size()), 32'(DEPTH + 32));
        // Only the final sample, where word_done is high, sees busy low.
        check("cw_busy_low", 32'(busy_low), 32'd1);
        errs = 0;
        for (int k = 0; k < wq_addr.size(); k++) begin
            if (k < DEPTH) begin
                if (wq_addr[k] !== 12'(k)) errs++;
                if (wq_data[k] !== 1'b1) errs++;
                if (wq_cyc[k] !== wq_cyc[0] + k) errs++;
            end else begin
                if (wq_addr[k] !== 12'(12'h123 + 12'(k - DEPTH))) errs++;
                if (wq_data[k] !== (k - DEPTH < 8)) errs++;
            end
        end
        check("cw_stream_errs", 32'(errs), 32'd0);
        if (wq_cyc.size() > DEPTH) begin
            check("cw_word_after_clr_done", 32'(wq_cyc[DEPTH] - cd_cyc), 32'd2);
        end else begin
            check("cw_word_started", 32'(wq_cyc.size()), 32'(DEPTH + 32));
        end

        // Asynchronous reset in the middle of a clear.
        step();
        clear_log();
        clr_value = 1'b1; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        t = 0;
        while (!(wren && wraddress == 12'h100) && t < 500) begin step(); t++; end
        check("rst_reached_0x100", 32'(wraddress), 32'h100);
        reset_n = 1'b0;
        #1;
        check("rst_async_wren", 32'(wren), 32'd0);
        check("rst_async_addr", 32'(wraddress), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        step();
        reset_n = 1'b1;
        clear_log();
        repeat (20) step();
        check("rst_no_writes", 32'(wq_addr.size()), 32'd0);
        check("rst_no_clr_done", 32'(cd_cnt), 32'd0);
        check("rst_idle_busy_low", 32'(busy_low), 32'd20);

        // Two word starts while pending behind a running job: latest operands win.
        clear_log();
        word_data = 32'h0; word_base = 12'h100; word_start = 1'b1;
        step();
        word_start = 1'b0;
        repeat (5) step();
        word_data = 32'h1; word_base = 12'h200; word_start = 1'b1;
        step();
        word_data = 32'h2;
        step();
        word_start = 1'b0;
        t = 0;
        while (wd_cnt < 2 && t < 300) begin step(); t++; end
        repeat (40) step();
        check("ovr_word_done_cnt", 32'(wd_cnt), 32'd2);
        check("ovr_nwrites", 32'(wq_addr.size()), 32'd64);
        errs = 0;
        for (int k = 0; k < wq_addr.size(); k++) begin
            if (k < 32) begin
                if (wq_addr[k] !== 12'(12'h100 + 12'(k))) errs++;
                if (wq_data[k] !== 1'b0) errs++;
            end else begin
                if (wq_addr[k] !== 12'(12'h200 + 12'(k - 32))) errs++;
                if (wq_data[k] !== (k == 33)) errs++;
            end
        end
        check("ovr_stream_errs", 32'(errs), 32'd0);
        check("ovr_final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
